// File: rtl/multi_store_seq_pkg.sv
// Shared definitions for the store-multiple sequencer: state encoding,
// register/word constants and the register-data source encodings that the
// writeback mux also uses.
package multi_store_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Register index stored when the PUSH extra bit is set.
    localparam logic [3:0]  LR_IDX_DEF = 4'd14;
    // Byte step between consecutive word addresses.
    localparam logic [31:0] WORD_INC   = 32'd4;

    // Register-file write data source select, shared with the writeback mux.
    typedef enum logic [1:0] {
        W_REG_DATA_SRC_ALU  = 2'd0,
        W_REG_DATA_SRC_MEM  = 2'd1,
        W_REG_DATA_SRC_PC   = 2'd2,
        W_REG_DATA_SRC_BASE = 2'd3
    } w_reg_data_src_t;

endpackage

// File: rtl/multi_store_seq_lowest_set_bit.sv
// 9-bit priority encoder: index of the lowest set bit plus a valid flag.
// Also used by the load-multiple sequencer.
module lowest_set_bit (
    input  logic [8:0] i_vec,
    output logic [3:0] o_idx,
    output logic       o_valid
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        o_idx   = 4'd0;
        o_valid = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = 4'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_store_seq.sv
// Store-multiple sequencer for STMIA / PUSH. Walks the register list lowest
// register first, one register-file read and one memory write per beat,
// then signals completion and the base/SP writeback.
// Build option: MULTI_STORE_BASE_WB_EN enables the base/SP writeback outputs;
// when undefined, wb_base_en and wb_base_data are tied to 0.
module multi_store_seq
    import multi_store_seq_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [3:0] LR_IDX = LR_IDX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_push,
    input  logic [7:0]        reg_list,
    input  logic              extra_bit,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] r_reg_data,
    input  logic              mem_ready,
    output logic [3:0]        r_reg_addr,
    output logic              w_mem_en,
    output logic [ADDR_W-1:0] w_mem_addr,
    output logic [ADDR_W-1:0] w_mem_data,
    output logic              busy,
    output logic              done,
    output logic              wb_base_en,
    output logic [ADDR_W-1:0] wb_base_data
);

    localparam logic [ADDR_W-1:0] W_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [8:0]        r_pending;
    logic [ADDR_W-1:0] r_addr;

    logic [8:0]        w_pending_in;
    logic [3:0]        w_cnt;
    logic [ADDR_W-1:0] w_base_al;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_start_addr;
    logic [3:0]        w_lsb_idx;
    logic              w_lsb_vld;
    logic [8:0]        w_pending_clr;
    logic              w_in_store;

    // Pending set seen at start; LR only participates for PUSH.
    assign w_pending_in = {extra_bit & is_push, reg_list};

    // Inline popcount of the pending set.
    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            w_cnt = w_cnt + 4'(w_pending_in[i]);
        end
    end

    assign w_base_al    = base_addr & W_ALIGN_MASK;
    assign w_span       = ADDR_W'({w_cnt, 2'b00});
    // Full-descending PUSH puts the block below SP; lowest register is still
    // written to the lowest address, so both modes walk upwards.
    assign w_start_addr = is_push ? (w_base_al - w_span) : w_base_al;

    lowest_set_bit u_lsb (
        .i_vec   (r_pending),
        .o_idx   (w_lsb_idx),
        .o_valid (w_lsb_vld)
    );

    assign w_pending_clr = r_pending & ~(9'd1 << w_lsb_idx);
    assign w_in_store    = (r_state == ST_STORE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = (w_cnt != 4'd0) ? ST_STORE : ST_DONE;
            ST_STORE: if (mem_ready && (w_pending_clr == 9'd0)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Pending list and address counter; advance only on accepted writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 9'd0;
            r_addr    <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_pending <= w_pending_in;
            r_addr    <= w_start_addr;
        end else if (w_in_store && mem_ready) begin
            r_pending <= w_pending_clr;
            r_addr    <= r_addr + ADDR_W'(WORD_INC);
        end
    end

    // Memory-side outputs are state-decoded so they are 0 outside STORE and
    // have no path from mem_ready; data is passed straight from the regfile.
    assign w_mem_en   = w_in_store;
    assign w_mem_addr = w_in_store ? r_addr : '0;
    assign w_mem_data = w_in_store ? r_reg_data : '0;
    assign r_reg_addr = (w_in_store && w_lsb_vld) ?
                        ((w_lsb_idx == 4'd8) ? LR_IDX : w_lsb_idx) : 4'd0;

    assign busy = (r_state != ST_IDLE) | start;
    assign done = (r_state == ST_DONE);

`ifdef MULTI_STORE_BASE_WB_EN
    logic [ADDR_W-1:0] r_final_base;
    logic [ADDR_W-1:0] w_final_base;

    assign w_final_base = is_push ? (w_base_al - w_span) : (w_base_al + w_span);

    // Final base is captured at start and held until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_final_base <= '0;
        else if (r_state == ST_IDLE && start) r_final_base <= w_final_base;
    end

    assign wb_base_en   = (r_state == ST_DONE);
    assign wb_base_data = r_final_base;
`else
    assign wb_base_en   = 1'b0;
    assign wb_base_data = '0;
`endif

endmodule

// File: doc/multi_store_seq.md
# multi_store_seq

Sequencer for STMIA and PUSH register-list instructions. It is the read-side counterpart of the multiple-load writeback path: it walks the register list and reads one register per beat from the register file. Each value goes to data memory at consecutive word addresses, and the sequencer then issues the base/SP writeback. It sits between decode and the data-memory write port and stalls the pipeline while it runs.

## Interface
Parameters:
- ADDR_W, 32, memory address and data width
- LR_IDX, 4'd14, register index stored for the PUSH extra bit

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request from decode; sampled only in IDLE
- is_push  in  1  1 = PUSH (full-descending, base = SP), 0 = STMIA (increment-after)
- reg_list  in  8  R0–R7 select bits
- extra_bit  in  1  PUSH only: also store LR; ignored when is_push=0
- base_addr  in  32  Rn/SP value at start
- r_reg_data  in  32  register-file read data for r_reg_addr (combinational)
- mem_ready  in  1  memory accepts the write this cycle
- r_reg_addr  out  4  register index being read
- w_mem_en  out  1  memory write strobe
- w_mem_addr  out  32  word-aligned write address
- w_mem_data  out  32  write data (= r_reg_data)
- busy  out  1  pipeline stall
- done  out  1  one-cycle completion pulse
- wb_base_en  out  1  base/SP register write enable
- wb_base_data  out  32  new base/SP value

## Operation
- States: IDLE, STORE, DONE.
- IDLE + start:
  - latch pending = {extra_bit & is_push, reg_list};
  - latch cnt = popcount(pending).
- Start address is base_addr − 4·cnt for PUSH and base_addr for STMIA; it is loaded into the address counter.
- Final base is base_addr − 4·cnt for PUSH and base_addr + 4·cnt for STMIA; it is latched in wb_base_data.
- Next state is STORE if cnt ≠ 0, else DONE.
- STORE:
  - r_reg_addr = index of the lowest set pending bit (bit 8 maps to LR_IDX).
  - w_mem_en = 1, w_mem_addr = address counter, w_mem_data = r_reg_data.
- On a STORE edge with mem_ready = 1:
  - clear that pending bit;
  - add 4 to the address counter (modulo 2^32; wrap is not flagged);
  - go to DONE if no bits remain.
- mem_ready = 0 holds all STORE outputs stable.
- Lowest register always goes to the lowest address, for both modes.
- DONE: done = 1 and wb_base_en = 1 for exactly one cycle, then IDLE.
- Empty list (cnt = 0): no memory writes; DONE writes back the unchanged base.
- start outside IDLE is ignored.
- base_addr[1:0] is ignored; addresses are forced word-aligned.

## Timing
- Reset: state = IDLE, pending = 0, all outputs 0 (busy, done, w_mem_en, wb_base_en, r_reg_addr, w_mem_addr, w_mem_data, wb_base_data).
- Reset mid-sequence aborts immediately. No further writes and no writeback.
- busy = (state ≠ IDLE) | (state == IDLE & start), so the issuing cycle already stalls.
- Latency with mem_ready held at 1 and N registers:
  - first write one cycle after start;
  - one write per cycle;
  - done N+1 cycles after start;
  - busy is high for N+2 cycles.
- Empty list: done and wb_base_en one cycle after start.
- Each wait cycle (mem_ready = 0) adds one cycle.
- w_mem_en, w_mem_addr and r_reg_addr are registered or state-decoded, with no combinational path from mem_ready.
- w_mem_data passes combinationally from r_reg_data.

## Configuration
- MULTI_STORE_BASE_WB_EN:
  - Defined: writeback behaves as described above.
  - Undefined: wb_base_en is tied to 0, the final-base logic is removed, and wb_base_data is tied to 0. Decode then handles base update through the ALU path.
- Write addresses and done timing are identical in both builds.

## Structure
- Shared package holds:
  - state encoding (IDLE/STORE/DONE);
  - LR_IDX and the word-increment constant 32'd4;
  - w_reg_data_src encodings, already shared with the writeback mux.
- Sub-module lowest_set_bit: 9-bit priority encoder producing a 4-bit index plus a valid flag. It is reused by the load-multiple sequencer.
- Popcount stays inline.

## Test plan
- STMIA reg_list = 8'b0000_0101, base = 0x100, mem_ready = 1:
  - writes R0 @0x100, then R2 @0x104;
  - done on cycle 3;
  - wb_base_data = 0x108.
- PUSH reg_list = 8'b1000_0001, extra_bit = 1, SP = 0x200:
  - writes R0 @0x1F4, R7 @0x1F8, R14 @0x1FC;
  - wb_base_data = 0x1F4.
- Same PUSH with mem_ready low for 2 cycles on the second beat:
  - R7 address and data held stable for those cycles;
  - done delayed by 2.
- Empty list, base = 0x40:
  - no w_mem_en;
  - done and wb_base_en the cycle after start, wb_base_data = 0x40.
- STMIA reg_list = 8'hFF, base = 0xFFFF_FFF0:
  - addresses wrap to 0x0000_0000 at R4;
  - 8 writes;
  - start pulses during busy are ignored.
- Assert rst during the third beat:
  - all outputs 0 asynchronously;
  - no writeback;
  - a new start after reset runs normally.
